beta_exe_mc_sequencer: RTL and testbench

BETA_EXE_MC_SEQUENCER -- requirements
Module: beta_exe_mc_sequencer

---
 rtl/beta_exe_mc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_beta_exe_mc_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_exe_mc_sequencer.sv
// Execute-stage sequencer: runs single-cycle instructions directly, hands multicycle ones to a unit,
// and queues decode traffic in a small pending FIFO. Define BETA_EXE_MCSEQ_TIMEOUT_EN for the watchdog abort.
module beta_exe_mc_sequencer #(
    parameter int NumUnits      = 2,
    parameter int PendDepth     = 2,
    parameter int TimeoutCycles = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           new_instr_i,
    input  logic [NumUnits-1:0]            instr_unit_i,
    input  logic                           instr_wr_en_i,
    output logic [NumUnits-1:0]            unit_start_o,
    input  logic [NumUnits-1:0]            unit_busy_i,
    output logic                           reg_wr_en_o,
    output logic                           stage_busy_o,
    output logic                           instr_accept_o,
    output logic [$clog2(PendDepth+1)-1:0] pend_cnt_o,
    output logic                           overflow_o,
    output logic                           timeout_o
);

    localparam int CntW = $clog2(PendDepth + 1);
    localparam int PtrW = $clog2(PendDepth);
    localparam logic [CntW-1:0] DepthC  = CntW'(PendDepth);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    if (NumUnits < 1 || NumUnits > 8) begin : g_bad_units
        $error("NumUnits must be in 1..8");
    end
    if (PendDepth < 2 || (PendDepth & (PendDepth - 1)) != 0) begin : g_bad_depth
        $error("PendDepth must be a power of 2, at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC1     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        WB        = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [NumUnits-1:0] cur_unit;
    logic                cur_wr;
    logic [NumUnits-1:0] fifo_unit [PendDepth];
    logic [PendDepth-1:0] fifo_wr;
    logic [PtrW-1:0]     rd_ptr, wr_ptr;
    logic [CntW-1:0]     cnt;
    logic                overflow_q;

    logic                illegal, accept, fifo_empty, bypass, pop, push, load, drop;
    logic [NumUnits-1:0] new_unit, load_unit, start;
    logic                load_wr, wr_pulse, busy_state, active_busy;
`ifdef BETA_EXE_MCSEQ_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
    localparam logic [WdW-1:0] WdOne  = WdW'(1);
    logic [WdW-1:0] wd_cnt;
    logic           wd_abort;
    logic           timeout_q;
`endif

    // Multi-hot unit fields resolve to the lowest set index.
    function automatic logic [NumUnits-1:0] lowest_unit(input logic [NumUnits-1:0] v);
        logic [NumUnits-1:0] r;
        logic                found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NumUnits; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        illegal     = !(state inside {IDLE, EXEC1, ISSUE, WAIT_BUSY, WAIT_DONE, WB});
        new_unit    = lowest_unit(instr_unit_i);
        fifo_empty  = (cnt == '0);
        drop        = new_instr_i && (cnt == DepthC);
        accept      = new_instr_i && (cnt < DepthC) && !rst_i && !illegal;
        bypass      = accept && (state == IDLE) && fifo_empty;
        pop         = (state == IDLE) && !fifo_empty && !rst_i;
        push        = accept && !bypass;
        load        = bypass || pop;
        load_unit   = bypass ? new_unit : fifo_unit[rd_ptr];
        load_wr     = bypass ? instr_wr_en_i : fifo_wr[rd_ptr];
        active_busy = |(unit_busy_i & cur_unit);

        state_nxt  = state;
        start      = '0;
        wr_pulse   = 1'b0;
        busy_state = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) state_nxt = (|load_unit) ? ISSUE : EXEC1;
            end
            EXEC1: begin
                wr_pulse  = cur_wr;
                state_nxt = IDLE;
            end
            ISSUE: begin
                busy_state = 1'b1;
                start      = cur_unit;
                if (active_busy) state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                busy_state = 1'b1;
                if (!active_busy) state_nxt = WB;
            end
            WAIT_DONE: begin
                busy_state = 1'b1;
                state_nxt  = IDLE;
            end
            WB: begin
                wr_pulse  = cur_wr;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

`ifdef BETA_EXE_MCSEQ_TIMEOUT_EN
        // The watchdog wins over a same-cycle busy handshake.
        wd_abort = ((state == ISSUE) || (state == WAIT_BUSY)) && (wd_cnt == WdLast);
        if (wd_abort) state_nxt = IDLE;
`endif
    end

    assign unit_start_o   = rst_i ? '0 : start;
    assign reg_wr_en_o    = !rst_i && wr_pulse;
    assign stage_busy_o   = !rst_i && !illegal && (busy_state || !fifo_empty);
    assign instr_accept_o = accept;
    assign pend_cnt_o     = cnt;
    assign overflow_o     = overflow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PtrOne;
            if (pop)  rd_ptr <= rd_ptr + PtrOne;
            if (push && !pop)      cnt <= cnt + CntOne;
            else if (pop && !push) cnt <= cnt - CntOne;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; push/load are already blocked during reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_unit[wr_ptr] <= new_unit;
            fifo_wr[wr_ptr]   <= instr_wr_en_i;
        end
        if (load) begin
            cur_unit <= load_unit;
            cur_wr   <= load_wr;
        end
    end

`ifdef BETA_EXE_MCSEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_nxt == ISSUE) && (state != ISSUE))
                wd_cnt <= '0;
            else if ((state == ISSUE) || (state == WAIT_BUSY))
                wd_cnt <= wd_cnt + WdOne;
            if (wd_abort) timeout_q <= 1'b1;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_beta_exe_mc_sequencer.sv
// Self-checking bench for beta_exe_mc_sequencer: randomized transactions against a timing model
// derived from the instruction lifecycle, plus FIFO, overflow, reset-abort and watchdog scenarios.
module tb_beta_exe_mc_sequencer;

    localparam int NU = 2;
    localparam int PD = 2;
    localparam int TO = 8;
    localparam int CW = $clog2(PD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          new_instr;
    logic [NU-1:0] unit;
    logic          wr_en;
    logic [NU-1:0] unit_start;
    logic [NU-1:0] busy;
    logic          reg_wr_en;
    logic          stage_busy;
    logic          accept;
    logic [CW-1:0] pend_cnt;
    logic          overflow;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    beta_exe_mc_sequencer #(
        .NumUnits(NU), .PendDepth(PD), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .new_instr_i(new_instr), .instr_unit_i(unit),
        .instr_wr_en_i(wr_en), .unit_start_o(unit_start), .unit_busy_i(busy),
        .reg_wr_en_o(reg_wr_en), .stage_busy_o(stage_busy), .instr_accept_o(accept),
        .pend_cnt_o(pend_cnt), .overflow_o(overflow), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    // Convention: each task is entered 1 time unit after a rising edge and leaves the same way.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        new_instr = 1'b0;
        unit      = '0;
        wr_en     = 1'b0;
        busy      = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        vectors++; if (unit_start !== '0) begin miscompares++; $display("FAIL rst_start: got %b want 0", unit_start); end
        vectors++; if (reg_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr: got %b want 0", reg_wr_en); end
        vectors++; if (stage_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", stage_busy); end
        vectors++; if (pend_cnt !== '0) begin miscompares++; $display("FAIL rst_pend: got %0d want 0", pend_cnt); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_tmo: got %b want 0", timeout); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_cycle();
        for (int n = 0; n < 8; n++) begin
            logic w;
            w = 1'($urandom);
            for (int c = 0; c < 3; c++) begin
                new_instr = (c == 0);
                unit      = '0;
                wr_en     = w;
                busy      = NU'($urandom);
                @(negedge clk);
                if (c == 0) begin
                    vectors++; if (accept !== 1'b1) begin miscompares++; $display("FAIL sc_accept n%0d: got %b want 1", n, accept); end
                end
                vectors++; if (reg_wr_en !== (c == 1 ? w : 1'b0)) begin miscompares++; $display("FAIL sc_wr n%0d c%0d: got %b want %b", n, c, reg_wr_en, (c == 1 ? w : 1'b0)); end
                vectors++; if (stage_busy !== 1'b0) begin miscompares++; $display("FAIL sc_busy n%0d c%0d: got %b want 0", n, c, stage_busy); end
                vectors++; if (unit_start !== '0) begin miscompares++; $display("FAIL sc_start n%0d c%0d: got %b want 0", n, c, unit_start); end
                next_cycle();
            end
        end
        idle_inputs();
    endtask

    // Lifecycle of an instruction accepted in cycle 0 by an idle stage: the start request
    // runs from cycle 1 until the unit's busy is first seen (cycle 1+d); the write-back
    // comes one cycle after busy is seen low in the wait phase, i.e. cycle d+L+2.
    task automatic test_multicycle();
        for (int n = 0; n < 12; n++) begin
            logic [NU-1:0] req, onehot;
            int            k, d, len, wb;
            logic          w;
            req = NU'($urandom_range(1, (1 << NU) - 1));
            k = -1;
            for (int i = NU - 1; i >= 0; i--) if (req[i]) k = i;
            onehot = '0;
            onehot[k] = 1'b1;
            d   = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            w   = 1'($urandom);
            wb  = d + len + 2;
            for (int c = 0; c <= wb + 1; c++) begin
                logic [NU-1:0] exp_start;
                new_instr = (c == 0);
                unit      = req;
                wr_en     = w;
                busy      = NU'($urandom);
                busy[k]   = (c >= 1 + d) && (c <= d + len);
                exp_start = ((c >= 1) && (c <= 1 + d)) ? onehot : '0;
                @(negedge clk);
                if (c == 0) begin
                    vectors++; if (accept !== 1'b1) begin miscompares++; $display("FAIL mc_accept n%0d: got %b want 1", n, accept); end
                end
                vectors++; if (unit_start !== exp_start) begin miscompares++; $display("FAIL mc_start n%0d c%0d: got %b want %b", n, c, unit_start, exp_start); end
                vectors++; if (reg_wr_en !== (c == wb ? w : 1'b0)) begin miscompares++; $display("FAIL mc_wr n%0d c%0d: got %b want %b", n, c, reg_wr_en, (c == wb ? w : 1'b0)); end
                vectors++; if (stage_busy !== ((c >= 1) && (c < wb))) begin miscompares++; $display("FAIL mc_busy n%0d c%0d: got %b want %b", n, c, stage_busy, ((c >= 1) && (c < wb))); end
                next_cycle();
            end
        end
        idle_inputs();
    endtask

    // Three single-cycle instructions on consecutive cycles: bypass, FIFO push, then pop with push.
    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            logic [2:0] w;
            int         exp_pend [7];
            w = 3'($urandom);
            exp_pend = '{0, 0, 1, 1, 1, 0, 0};
            for (int c = 0; c < 7; c++) begin
                logic exp_wr;
                new_instr = (c < 3);
                unit      = '0;
                wr_en     = (c < 3) ? w[c] : 1'b0;
                busy      = '0;
                exp_wr    = (c == 1) ? w[0] : (c == 3) ? w[1] : (c == 5) ? w[2] : 1'b0;
                @(negedge clk);
                if (c < 3) begin
                    vectors++; if (accept !== 1'b1) begin miscompares++; $display("FAIL b2b_accept n%0d c%0d: got %b want 1", n, c, accept); end
                end
                vectors++; if (reg_wr_en !== exp_wr) begin miscompares++; $display("FAIL b2b_wr n%0d c%0d: got %b want %b", n, c, reg_wr_en, exp_wr); end
                vectors++; if (pend_cnt !== CW'(exp_pend[c])) begin miscompares++; $display("FAIL b2b_pend n%0d c%0d: got %0d want %0d", n, c, pend_cnt, exp_pend[c]); end
                vectors++; if (stage_busy !== (exp_pend[c] != 0)) begin miscompares++; $display("FAIL b2b_busy n%0d c%0d: got %b want %b", n, c, stage_busy, (exp_pend[c] != 0)); end
                next_cycle();
            end
        end
        idle_inputs();
    endtask

    // Unit-1 op (busy cycles 1..5) with three instructions arriving during it: A single-cycle,
    // B on unit 0, C dropped. Afterwards A writes, then B starts on unit 0.
    task automatic test_overflow();
        logic [NU-1:0] exp_start [15];
        int            exp_pend  [15];
        logic [14:0]   exp_wr, exp_busy, exp_acc;
        exp_pend = '{0, 0, 0, 1, 2, 2, 2, 2, 2, 1, 1, 0, 0, 0, 0};
        for (int c = 0; c < 15; c++) exp_start[c] = '0;
        exp_start[1]  = 2'b10;
        exp_start[11] = 2'b01;
        exp_wr   = '0; exp_wr[7] = 1'b1; exp_wr[9] = 1'b1; exp_wr[13] = 1'b1;
        exp_busy = '0; for (int c = 1; c <= 12; c++) exp_busy[c] = 1'b1;
        exp_acc  = '0; exp_acc[0] = 1'b1; exp_acc[2] = 1'b1; exp_acc[3] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            idle_inputs();
            case (c)
                0: begin new_instr = 1'b1; unit = 2'b10; wr_en = 1'b1; end
                2: begin new_instr = 1'b1; unit = 2'b00; wr_en = 1'b1; end
                3: begin new_instr = 1'b1; unit = 2'b01; wr_en = 1'b1; end
                4: begin new_instr = 1'b1; unit = 2'b00; wr_en = 1'b0; end
                default: ;
            endcase
            busy[1] = (c >= 1) && (c <= 5);
            busy[0] = (c >= 1 && c <= 6) ? 1'($urandom) : (c == 11);
            @(negedge clk);
            vectors++; if (accept !== exp_acc[c]) begin miscompares++; $display("FAIL ovf_accept c%0d: got %b want %b", c, accept, exp_acc[c]); end
            vectors++; if (unit_start !== exp_start[c]) begin miscompares++; $display("FAIL ovf_start c%0d: got %b want %b", c, unit_start, exp_start[c]); end
            vectors++; if (reg_wr_en !== exp_wr[c]) begin miscompares++; $display("FAIL ovf_wr c%0d: got %b want %b", c, reg_wr_en, exp_wr[c]); end
            vectors++; if (pend_cnt !== CW'(exp_pend[c])) begin miscompares++; $display("FAIL ovf_pend c%0d: got %0d want %0d", c, pend_cnt, exp_pend[c]); end
            vectors++; if (stage_busy !== exp_busy[c]) begin miscompares++; $display("FAIL ovf_busy c%0d: got %b want %b", c, stage_busy, exp_busy[c]); end
            vectors++; if (overflow !== (c >= 5)) begin miscompares++; $display("FAIL ovf_flag c%0d: got %b want %b", c, overflow, (c >= 5)); end
            next_cycle();
        end
        idle_inputs();
    endtask

    // Reset while waiting on a busy unit with one instruction queued.
    task automatic test_reset_abort();
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            rst = (c == 4);
            if (c == 0) begin new_instr = 1'b1; unit = 2'b10; wr_en = 1'b1; end
            if (c == 2) begin new_instr = 1'b1; unit = 2'b00; wr_en = 1'b1; end
            busy[1] = (c >= 1) && (c <= 4);
            @(negedge clk);
            if (c == 3) begin
                vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ra_ovf_sticky: got %b want 1", overflow); end
                vectors++; if (pend_cnt !== CW'(1)) begin miscompares++; $display("FAIL ra_pend_pre: got %0d want 1", pend_cnt); end
            end
            if (c >= 4) begin
                vectors++; if (unit_start !== '0) begin miscompares++; $display("FAIL ra_start c%0d: got %b want 0", c, unit_start); end
                vectors++; if (reg_wr_en !== 1'b0) begin miscompares++; $display("FAIL ra_wr c%0d: got %b want 0", c, reg_wr_en); end
                vectors++; if (stage_busy !== 1'b0) begin miscompares++; $display("FAIL ra_busy c%0d: got %b want 0", c, stage_busy); end
            end
            if (c >= 5) begin
                vectors++; if (pend_cnt !== '0) begin miscompares++; $display("FAIL ra_pend c%0d: got %0d want 0", c, pend_cnt); end
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ra_ovf c%0d: got %b want 0", c, overflow); end
                vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL ra_tmo c%0d: got %b want 0", c, timeout); end
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    // Unit busy rises with the start request and never falls on its own.
    task automatic test_timeout();
        logic w;
        w = 1'b1;
`ifdef BETA_EXE_MCSEQ_TIMEOUT_EN
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            if (c == 0) begin new_instr = 1'b1; unit = 2'b10; wr_en = w; end
            busy[1] = (c >= 1);
            @(negedge clk);
            vectors++; if (stage_busy !== ((c >= 1) && (c <= TO))) begin miscompares++; $display("FAIL to_busy c%0d: got %b want %b", c, stage_busy, ((c >= 1) && (c <= TO))); end
            vectors++; if (timeout !== (c >= TO + 1)) begin miscompares++; $display("FAIL to_flag c%0d: got %b want %b", c, timeout, (c >= TO + 1)); end
            vectors++; if (reg_wr_en !== 1'b0) begin miscompares++; $display("FAIL to_wr c%0d: got %b want 0", c, reg_wr_en); end
            vectors++; if (unit_start !== (c == 1 ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL to_start c%0d: got %b want %b", c, unit_start, (c == 1 ? 2'b10 : 2'b00)); end
            next_cycle();
        end
`else
        for (int c = 0; c < 44; c++) begin
            idle_inputs();
            if (c == 0) begin new_instr = 1'b1; unit = 2'b10; wr_en = w; end
            busy[1] = (c >= 1) && (c <= 40);
            @(negedge clk);
            vectors++; if (stage_busy !== ((c >= 1) && (c <= 41))) begin miscompares++; $display("FAIL nto_busy c%0d: got %b want %b", c, stage_busy, ((c >= 1) && (c <= 41))); end
            vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nto_flag c%0d: got %b want 0", c, timeout); end
            vectors++; if (reg_wr_en !== (c == 42 ? w : 1'b0)) begin miscompares++; $display("FAIL nto_wr c%0d: got %b want %b", c, reg_wr_en, (c == 42 ? w : 1'b0)); end
            next_cycle();
        end
`endif
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_single_cycle();
        test_multicycle();
        test_back_to_back();
        test_overflow();
        test_reset_abort();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
